core2axi4l_pipelined: RTL and testbench

//  Bridge from the Ibex core request/grant/rvalid memory port to an AXI4-Lite master.

---
 rtl/core2axi4l_pipelined_pkg.sv | 25 ++
 rtl/core2axi4l_pipelined_if.sv | 69 ++++++
 rtl/core2axi4l_pipelined_order_fifo.sv | 62 ++++++
 rtl/core2axi4l_pipelined.sv | 211 +++++++++++++++++++++
 tb/tb_core2axi4l_pipelined.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core2axi4l_pipelined_pkg.sv
// Shared AXI4-Lite types and constants for the pipelined core-to-AXI4-Lite bridge.
// Imported by the order FIFO and the bridge top level.
package axi4l_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic {
        TXN_READ  = 1'b0,
        TXN_WRITE = 1'b1
    } txn_e;

    localparam logic [2:0] PROT_DATA  = 3'b000;
    localparam logic [2:0] PROT_INSTR = 3'b100;

    // SLVERR and DECERR are the error responses; both have resp[1] set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == SLVERR) || (resp == DECERR);
    endfunction

endpackage

// File: rtl/core2axi4l_pipelined_if.sv
// Bus interfaces of the bridge: the Ibex-style req/gnt/rvalid core port
// and the AXI4-Lite master port, each with master/slave modports.
interface core2axi4l_core_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    localparam int StrbWidth = DataWidth / 8;

    logic                 core_req;
    logic                 core_gnt;
    logic                 core_we;
    logic [StrbWidth-1:0] core_be;
    logic [AddrWidth-1:0] core_addr;
    logic [DataWidth-1:0] core_wdata;
    logic                 core_rvalid;
    logic [DataWidth-1:0] core_rdata;
    logic                 core_err;

    modport master (
        output core_req, core_we, core_be, core_addr, core_wdata,
        input  core_gnt, core_rvalid, core_rdata, core_err
    );

    modport slave (
        input  core_req, core_we, core_be, core_addr, core_wdata,
        output core_gnt, core_rvalid, core_rdata, core_err
    );
endinterface

interface core2axi4l_axi_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    localparam int StrbWidth = DataWidth / 8;

    logic                 axi_awvalid;
    logic                 axi_awready;
    logic [AddrWidth-1:0] axi_awaddr;
    logic [2:0]           axi_awprot;
    logic                 axi_wvalid;
    logic                 axi_wready;
    logic [DataWidth-1:0] axi_wdata;
    logic [StrbWidth-1:0] axi_wstrb;
    logic                 axi_bvalid;
    logic                 axi_bready;
    logic [1:0]           axi_bresp;
    logic                 axi_arvalid;
    logic                 axi_arready;
    logic [AddrWidth-1:0] axi_araddr;
    logic [2:0]           axi_arprot;
    logic                 axi_rvalid;
    logic                 axi_rready;
    logic [DataWidth-1:0] axi_rdata;
    logic [1:0]           axi_rresp;

    modport master (
        output axi_awvalid, axi_awaddr, axi_awprot, axi_wvalid, axi_wdata, axi_wstrb,
               axi_bready, axi_arvalid, axi_araddr, axi_arprot, axi_rready,
        input  axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_arready,
               axi_rvalid, axi_rdata, axi_rresp
    );

    modport slave (
        input  axi_awvalid, axi_awaddr, axi_awprot, axi_wvalid, axi_wdata, axi_wstrb,
               axi_bready, axi_arvalid, axi_araddr, axi_arprot, axi_rready,
        output axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_arready,
               axi_rvalid, axi_rdata, axi_rresp
    );
endinterface

// File: rtl/core2axi4l_pipelined_order_fifo.sv
// Small synchronous FIFO recording the type of each granted transaction.
// A push is accepted while full as long as a pop happens in the same cycle.
module axi4l_order_fifo #(
    parameter int Depth = 2,
    parameter int Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [Width-1:0] i_data,
    input  logic             i_pop,
    output logic [Width-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CntW'(Depth));
    assign o_data    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // NOTE: storage has no reset; an entry is only read after it was written, and
    // leaving it out of the reset keeps it a plain register array.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every reader sees the
    // pre-edge value regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop_ok)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/core2axi4l_pipelined.sv
// Pipelined bridge from the Ibex req/gnt/rvalid memory port to an AXI4-Lite master,
// with up to MaxOutstanding transactions in flight and in-order responses.
module core2axi4l_pipelined
    import axi4l_pkg::*;
#(
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 2,
    parameter bit WriteEnable    = 1'b1,
    parameter bit InstrPort      = 1'b0,
    parameter bit StrictOrder    = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    core2axi4l_core_if.slave    core,
    core2axi4l_axi_if.master    axi
);
    localparam int StrbWidth = DataWidth / 8;
    localparam int CntW      = $clog2(MaxOutstanding + 1);

    logic                 r_arvalid;
    logic [AddrWidth-1:0] r_araddr;
    logic                 r_awvalid;
    logic [AddrWidth-1:0] r_awaddr;
    logic                 r_wvalid;
    logic [DataWidth-1:0] r_wdata;
    logic [StrbWidth-1:0] r_wstrb;
    logic [CntW-1:0]      r_cnt;
    logic [CntW-1:0]      r_n_rd;
    logic [CntW-1:0]      r_n_wr;
    logic                 r_rvalid;
    logic [DataWidth-1:0] r_rdata;
    logic                 r_err;

    logic w_is_write;
    logic w_ar_free;
    logic w_aw_free;
    logic w_w_free;
    logic w_slot_ok;
    logic w_hold_ok;
    logic w_order_ok;
    logic w_gnt;
    logic w_gnt_rd;
    logic w_gnt_wr;
    logic w_fifo_head;
    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_rready;
    logic w_bready;
    logic w_r_hs;
    logic w_b_hs;
    txn_e w_push_txn;

    // ------------------------------------------------------------------
    // Grant logic: combinational so a free slot can be refilled every cycle
    // ------------------------------------------------------------------
    assign w_is_write = WriteEnable && core.core_we;
    assign w_ar_free  = !r_arvalid || axi.axi_arready;
    assign w_aw_free  = !r_awvalid || axi.axi_awready;
    assign w_w_free   = !r_wvalid  || axi.axi_wready;
    assign w_slot_ok  = (r_cnt < CntW'(MaxOutstanding)) || r_rvalid;
    assign w_hold_ok  = w_is_write ? (w_aw_free && w_w_free) : w_ar_free;
    assign w_order_ok = !StrictOrder || (w_is_write ? (r_n_rd == '0) : (r_n_wr == '0));
    assign w_gnt      = core.core_req && w_slot_ok && w_hold_ok && w_order_ok;
    assign w_gnt_rd   = w_gnt && !w_is_write;
    assign w_gnt_wr   = w_gnt && w_is_write;
    assign w_push_txn = w_is_write ? TXN_WRITE : TXN_READ;

    assign core.core_gnt = w_gnt;

    // ------------------------------------------------------------------
    // Order FIFO: only the channel matching the oldest transaction is ready
    // ------------------------------------------------------------------
    axi4l_order_fifo #(
        .Depth (MaxOutstanding),
        .Width (1)
    ) u_order_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_gnt),
        .i_data  (w_push_txn),
        .i_pop   (w_r_hs || w_b_hs),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_rready = !w_fifo_empty && (txn_e'(w_fifo_head) == TXN_READ);
    assign w_bready = WriteEnable && !w_fifo_empty && (txn_e'(w_fifo_head) == TXN_WRITE);
    assign w_r_hs   = axi.axi_rvalid && w_rready;
    assign w_b_hs   = axi.axi_bvalid && w_bready;

    // ------------------------------------------------------------------
    // Request hold registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
        end else if (w_gnt_rd) begin
            r_arvalid <= 1'b1;
            r_araddr  <= core.core_addr;
        end else if (axi.axi_arready) begin
            r_arvalid <= 1'b0;
        end
    end

    // AW and W retire independently; a new write needs both to be free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_awvalid <= 1'b0;
            r_awaddr  <= '0;
            r_wvalid  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            if (w_gnt_wr) begin
                r_awvalid <= 1'b1;
                r_awaddr  <= core.core_addr;
            end else if (axi.axi_awready) begin
                r_awvalid <= 1'b0;
            end
            if (w_gnt_wr) begin
                r_wvalid <= 1'b1;
                r_wdata  <= core.core_wdata;
                r_wstrb  <= core.core_be;
            end else if (axi.axi_wready) begin
                r_wvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outstanding counters: total, plus reads/writes still in the FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_n_rd <= '0;
            r_n_wr <= '0;
        end else begin
            case ({w_gnt, r_rvalid})
                2'b10:   r_cnt <= r_cnt + CntW'(1);
                2'b01:   r_cnt <= r_cnt - CntW'(1);
                default: r_cnt <= r_cnt;
            endcase
            case ({w_gnt_rd, w_r_hs})
                2'b10:   r_n_rd <= r_n_rd + CntW'(1);
                2'b01:   r_n_rd <= r_n_rd - CntW'(1);
                default: r_n_rd <= r_n_rd;
            endcase
            case ({w_gnt_wr, w_b_hs})
                2'b10:   r_n_wr <= r_n_wr + CntW'(1);
                2'b01:   r_n_wr <= r_n_wr - CntW'(1);
                default: r_n_wr <= r_n_wr;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response register: one core_rvalid pulse per R/B handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_r_hs || w_b_hs;
            if (w_r_hs) begin
                r_rdata <= axi.axi_rdata;
                r_err   <= resp_is_err(axi.axi_rresp);
            end else if (w_b_hs) begin
                r_rdata <= '0;
                r_err   <= resp_is_err(axi.axi_bresp);
            end else begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    assign core.core_rvalid = r_rvalid;
    assign core.core_rdata  = r_rdata;
    assign core.core_err    = r_err;

    assign axi.axi_arvalid = r_arvalid;
    assign axi.axi_araddr  = r_araddr;
    assign axi.axi_arprot  = InstrPort ? PROT_INSTR : PROT_DATA;
    assign axi.axi_rready  = w_rready;
    assign axi.axi_awvalid = r_awvalid;
    assign axi.axi_awaddr  = r_awaddr;
    assign axi.axi_awprot  = PROT_DATA;
    assign axi.axi_wvalid  = r_wvalid;
    assign axi.axi_wdata   = r_wdata;
    assign axi.axi_wstrb   = r_wstrb;
    assign axi.axi_bready  = w_bready;

    // Payload must stay put while the slave has not yet accepted it.
    a_ar_stable : assert property (@(posedge clk) disable iff (rst)
        (r_arvalid && !axi.axi_arready) |=> (r_arvalid && $stable(r_araddr)));
    a_aw_stable : assert property (@(posedge clk) disable iff (rst)
        (r_awvalid && !axi.axi_awready) |=> (r_awvalid && $stable(r_awaddr)));
    a_w_stable : assert property (@(posedge clk) disable iff (rst)
        (r_wvalid && !axi.axi_wready) |=> (r_wvalid && $stable(r_wdata) && $stable(r_wstrb)));
    a_cnt_bound : assert property (@(posedge clk) disable iff (rst)
        (r_cnt <= CntW'(MaxOutstanding)));
    a_fifo_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(w_gnt && w_fifo_full && !(w_r_hs || w_b_hs)));

endmodule

// File: tb/tb_core2axi4l_pipelined.sv
// Directed bench for core2axi4l_pipelined: a relaxed-order instance for the main
// sequences and a strict-order instruction-port instance for the ordering hold-off.
module tb_core2axi4l_pipelined;
    import axi4l_pkg::*;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    core2axi4l_core_if #(.AddrWidth(32), .DataWidth(32)) cbus ();
    core2axi4l_axi_if  #(.AddrWidth(32), .DataWidth(32)) abus ();
    core2axi4l_core_if #(.AddrWidth(32), .DataWidth(32)) sbus ();
    core2axi4l_axi_if  #(.AddrWidth(32), .DataWidth(32)) sabus ();

    core2axi4l_pipelined #(
        .AddrWidth(32), .DataWidth(32), .MaxOutstanding(2),
        .WriteEnable(1'b1), .InstrPort(1'b0), .StrictOrder(1'b0)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .core (cbus),
        .axi  (abus)
    );

    core2axi4l_pipelined #(
        .AddrWidth(32), .DataWidth(32), .MaxOutstanding(2),
        .WriteEnable(1'b1), .InstrPort(1'b1), .StrictOrder(1'b1)
    ) u_dut_strict (
        .clk  (clk),
        .rst  (rst),
        .core (sbus),
        .axi  (sabus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cbus.core_req = 1'b0;  cbus.core_we = 1'b0;  cbus.core_be = '0;
        cbus.core_addr = '0;   cbus.core_wdata = '0;
        abus.axi_awready = 1'b0; abus.axi_wready = 1'b0; abus.axi_arready = 1'b0;
        abus.axi_bvalid = 1'b0;  abus.axi_bresp = OKAY;
        abus.axi_rvalid = 1'b0;  abus.axi_rdata = '0;    abus.axi_rresp = OKAY;
        sbus.core_req = 1'b0;  sbus.core_we = 1'b0;  sbus.core_be = '0;
        sbus.core_addr = '0;   sbus.core_wdata = '0;
        sabus.axi_awready = 1'b0; sabus.axi_wready = 1'b0; sabus.axi_arready = 1'b0;
        sabus.axi_bvalid = 1'b0;  sabus.axi_bresp = OKAY;
        sabus.axi_rvalid = 1'b0;  sabus.axi_rdata = '0;    sabus.axi_rresp = OKAY;
    endtask

    // Single read with an immediately ready AR and the R beat one cycle after it.
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] resp, input logic exp_err);
        cbus.core_req = 1'b1; cbus.core_we = 1'b0; cbus.core_addr = addr;
        abus.axi_arready = 1'b1;
        sample(); check({tag, ".gnt"}, cbus.core_gnt, 1'b1);
        step();
        cbus.core_req = 1'b0;
        sample(); check({tag, ".arvalid"}, abus.axi_arvalid, 1'b1);
        step();
        abus.axi_arready = 1'b0;
        abus.axi_rvalid = 1'b1; abus.axi_rdata = data; abus.axi_rresp = resp;
        step();
        abus.axi_rvalid = 1'b0; abus.axi_rresp = OKAY;
        sample();
        check({tag, ".rvalid"}, cbus.core_rvalid, 1'b1);
        check({tag, ".rdata"}, cbus.core_rdata, data);
        check({tag, ".err"}, cbus.core_err, exp_err);
        step();
    endtask

    // Single write with AW and W accepted together and B one cycle later.
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] resp, input logic exp_err);
        cbus.core_req = 1'b1; cbus.core_we = 1'b1; cbus.core_addr = addr;
        cbus.core_wdata = data; cbus.core_be = 4'hF;
        abus.axi_awready = 1'b1; abus.axi_wready = 1'b1;
        sample(); check({tag, ".gnt"}, cbus.core_gnt, 1'b1);
        step();
        cbus.core_req = 1'b0; cbus.core_we = 1'b0;
        step();
        abus.axi_awready = 1'b0; abus.axi_wready = 1'b0;
        abus.axi_bvalid = 1'b1; abus.axi_bresp = resp;
        step();
        abus.axi_bvalid = 1'b0; abus.axi_bresp = OKAY;
        sample();
        check({tag, ".rvalid"}, cbus.core_rvalid, 1'b1);
        check({tag, ".rdata"}, cbus.core_rdata, 32'h0);
        check({tag, ".err"}, cbus.core_err, exp_err);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        idle_inputs();

        // Reset state
        repeat (2) step();
        sample();
        check("rst.arvalid", abus.axi_arvalid, 1'b0);
        check("rst.awvalid", abus.axi_awvalid, 1'b0);
        check("rst.wvalid",  abus.axi_wvalid,  1'b0);
        check("rst.rready",  abus.axi_rready,  1'b0);
        check("rst.bready",  abus.axi_bready,  1'b0);
        check("rst.rvalid",  cbus.core_rvalid, 1'b0);
        check("rst.rdata",   cbus.core_rdata,  32'h0);
        check("rst.err",     cbus.core_err,    1'b0);
        step();
        rst = 1'b0;
        step();

        // 1. Single read, R two cycles after the AR handshake cycle
        cbus.core_req = 1'b1; cbus.core_we = 1'b0; cbus.core_addr = 32'h100;
        sample(); check("t1.gnt", cbus.core_gnt, 1'b1);
        step();
        cbus.core_req = 1'b0; abus.axi_arready = 1'b1;
        sample();
        check("t1.arvalid", abus.axi_arvalid, 1'b1);
        check("t1.araddr",  abus.axi_araddr,  32'h100);
        check("t1.arprot",  abus.axi_arprot,  3'b000);
        step();
        abus.axi_arready = 1'b0;
        sample(); check("t1.arvalid_clr", abus.axi_arvalid, 1'b0);
        step();
        abus.axi_rvalid = 1'b1; abus.axi_rdata = 32'hDEADBEEF; abus.axi_rresp = OKAY;
        sample();
        check("t1.rready", abus.axi_rready, 1'b1);
        check("t1.no_early_rvalid", cbus.core_rvalid, 1'b0);
        step();
        abus.axi_rvalid = 1'b0;
        sample();
        check("t1.rvalid", cbus.core_rvalid, 1'b1);
        check("t1.rdata",  cbus.core_rdata,  32'hDEADBEEF);
        check("t1.err",    cbus.core_err,    1'b0);
        step();
        sample(); check("t1.rvalid_pulse", cbus.core_rvalid, 1'b0);

        // 2. Write with AW and W accepted in different cycles
        step();
        cbus.core_req = 1'b1; cbus.core_we = 1'b1; cbus.core_addr = 32'h200;
        cbus.core_wdata = 32'h12345678; cbus.core_be = 4'b0011;
        sample(); check("t2.gnt", cbus.core_gnt, 1'b1);
        step();
        cbus.core_req = 1'b0; cbus.core_we = 1'b0; abus.axi_awready = 1'b1;
        sample();
        check("t2.awvalid", abus.axi_awvalid, 1'b1);
        check("t2.awaddr",  abus.axi_awaddr,  32'h200);
        check("t2.wvalid",  abus.axi_wvalid,  1'b1);
        check("t2.wdata",   abus.axi_wdata,   32'h12345678);
        check("t2.wstrb",   abus.axi_wstrb,   4'b0011);
        step();
        abus.axi_awready = 1'b0;
        sample();
        check("t2.awvalid_clr", abus.axi_awvalid, 1'b0);
        check("t2.wvalid_hold", abus.axi_wvalid,  1'b1);
        step();
        abus.axi_wready = 1'b1;
        sample(); check("t2.wstrb_hold", abus.axi_wstrb, 4'b0011);
        step();
        abus.axi_wready = 1'b0; abus.axi_bvalid = 1'b1; abus.axi_bresp = OKAY;
        sample();
        check("t2.wvalid_clr", abus.axi_wvalid, 1'b0);
        check("t2.bready",     abus.axi_bready, 1'b1);
        step();
        abus.axi_bvalid = 1'b0;
        sample();
        check("t2.rvalid", cbus.core_rvalid, 1'b1);
        check("t2.rdata",  cbus.core_rdata,  32'h0);
        check("t2.err",    cbus.core_err,    1'b0);
        step();
        sample(); check("t2.rvalid_pulse", cbus.core_rvalid, 1'b0);

        // 3. Three back-to-back reads against MaxOutstanding=2
        step();
        cbus.core_req = 1'b1; cbus.core_we = 1'b0; cbus.core_addr = 32'h300;
        abus.axi_arready = 1'b1;
        sample(); check("t3.gnt0", cbus.core_gnt, 1'b1);
        step();
        cbus.core_addr = 32'h304;
        sample(); check("t3.gnt1", cbus.core_gnt, 1'b1);
        step();
        cbus.core_addr = 32'h308;
        sample();
        check("t3.gnt2_blocked", cbus.core_gnt, 1'b0);
        check("t3.araddr1",      abus.axi_araddr, 32'h304);
        step();
        abus.axi_rvalid = 1'b1; abus.axi_rdata = 32'hA1;
        sample();
        check("t3.gnt2_still_blocked", cbus.core_gnt, 1'b0);
        check("t3.rready", abus.axi_rready, 1'b1);
        step();
        abus.axi_rvalid = 1'b0;
        sample();
        check("t3.rvalid0", cbus.core_rvalid, 1'b1);
        check("t3.rdata0",  cbus.core_rdata,  32'hA1);
        check("t3.gnt2_on_resp", cbus.core_gnt, 1'b1);
        step();
        cbus.core_req = 1'b0;
        abus.axi_rvalid = 1'b1; abus.axi_rdata = 32'hA2;
        sample();
        check("t3.rvalid_gap", cbus.core_rvalid, 1'b0);
        check("t3.araddr2",    abus.axi_araddr,  32'h308);
        step();
        abus.axi_arready = 1'b0; abus.axi_rdata = 32'hA3;
        sample();
        check("t3.rdata1", cbus.core_rdata, 32'hA2);
        step();
        abus.axi_rvalid = 1'b0;
        sample();
        check("t3.rvalid2", cbus.core_rvalid, 1'b1);
        check("t3.rdata2",  cbus.core_rdata,  32'hA3);
        step();
        sample();
        check("t3.drained_rvalid", cbus.core_rvalid, 1'b0);
        check("t3.drained_rready", abus.axi_rready,  1'b0);

        // 4. Relaxed order: write then read, R offered before B
        step();
        cbus.core_req = 1'b1; cbus.core_we = 1'b1; cbus.core_addr = 32'h400;
        cbus.core_wdata = 32'h000055AA; cbus.core_be = 4'hF;
        sample(); check("t4.gnt_wr", cbus.core_gnt, 1'b1);
        step();
        cbus.core_we = 1'b0; cbus.core_addr = 32'h404;
        abus.axi_awready = 1'b1; abus.axi_wready = 1'b1;
        sample(); check("t4.gnt_rd", cbus.core_gnt, 1'b1);
        step();
        cbus.core_req = 1'b0;
        abus.axi_awready = 1'b0; abus.axi_wready = 1'b0; abus.axi_arready = 1'b1;
        sample(); check("t4.araddr", abus.axi_araddr, 32'h404);
        step();
        abus.axi_arready = 1'b0;
        abus.axi_rvalid = 1'b1; abus.axi_rdata = 32'hBEEF0001;
        sample();
        check("t4.rready_stall", abus.axi_rready, 1'b0);
        check("t4.bready",       abus.axi_bready, 1'b1);
        step();
        abus.axi_bvalid = 1'b1; abus.axi_bresp = OKAY;
        sample(); check("t4.rready_stall2", abus.axi_rready, 1'b0);
        step();
        abus.axi_bvalid = 1'b0;
        sample();
        check("t4.wr_rvalid", cbus.core_rvalid, 1'b1);
        check("t4.wr_rdata",  cbus.core_rdata,  32'h0);
        check("t4.rready_now", abus.axi_rready, 1'b1);
        step();
        abus.axi_rvalid = 1'b0;
        sample();
        check("t4.rd_rvalid", cbus.core_rvalid, 1'b1);
        check("t4.rd_rdata",  cbus.core_rdata,  32'hBEEF0001);
        step();

        // 5. Error mapping of response codes
        do_read ("t5.slverr", 32'h500, 32'h11, SLVERR, 1'b1);
        do_write("t5.decerr", 32'h504, 32'h22, DECERR, 1'b1);
        do_read ("t5.exokay", 32'h508, 32'h33, EXOKAY, 1'b0);

        // 6. Reset while two reads are in flight and AR is still pending
        cbus.core_req = 1'b1; cbus.core_we = 1'b0; cbus.core_addr = 32'h600;
        abus.axi_arready = 1'b1;
        sample(); check("t6.gnt0", cbus.core_gnt, 1'b1);
        step();
        cbus.core_addr = 32'h604;
        sample(); check("t6.gnt1", cbus.core_gnt, 1'b1);
        step();
        cbus.core_req = 1'b0; abus.axi_arready = 1'b0;
        sample(); check("t6.arvalid_pre", abus.axi_arvalid, 1'b1);
        #1 rst = 1'b1;
        abus.axi_rvalid = 1'b1; abus.axi_rdata = 32'hBAD;
        #1;
        check("t6.arvalid", abus.axi_arvalid, 1'b0);
        check("t6.rready",  abus.axi_rready,  1'b0);
        check("t6.rvalid",  cbus.core_rvalid, 1'b0);
        step();
        rst = 1'b0;
        sample(); check("t6.rready_after", abus.axi_rready, 1'b0);
        step();
        abus.axi_rvalid = 1'b0;
        cbus.core_req = 1'b1; cbus.core_addr = 32'h700;
        sample(); check("t6.new_gnt0", cbus.core_gnt, 1'b1);
        step();
        cbus.core_addr = 32'h704; abus.axi_arready = 1'b1;
        sample(); check("t6.new_gnt1", cbus.core_gnt, 1'b1);
        step();
        cbus.core_addr = 32'h708;
        sample(); check("t6.new_full", cbus.core_gnt, 1'b0);
        check("t6.araddr", abus.axi_araddr, 32'h704);
        step();
        cbus.core_req = 1'b0; abus.axi_arready = 1'b0;
        abus.axi_rvalid = 1'b1; abus.axi_rdata = 32'h70;
        step();
        abus.axi_rdata = 32'h74;
        sample(); check("t6.resp0", cbus.core_rdata, 32'h70);
        step();
        abus.axi_rvalid = 1'b0;
        sample(); check("t6.resp1", cbus.core_rdata, 32'h74);
        step();

        // Strict order on the instruction-port instance
        sbus.core_req = 1'b1; sbus.core_we = 1'b1; sbus.core_addr = 32'h800;
        sbus.core_wdata = 32'hCAFE; sbus.core_be = 4'hF;
        sample(); check("s.gnt_wr", sbus.core_gnt, 1'b1);
        step();
        sbus.core_we = 1'b0; sbus.core_addr = 32'h804;
        sabus.axi_awready = 1'b1; sabus.axi_wready = 1'b1;
        sample(); check("s.rd_held", sbus.core_gnt, 1'b0);
        step();
        sabus.axi_awready = 1'b0; sabus.axi_wready = 1'b0;
        sabus.axi_bvalid = 1'b1; sabus.axi_bresp = OKAY;
        sample();
        check("s.rd_held2", sbus.core_gnt, 1'b0);
        check("s.bready",   sabus.axi_bready, 1'b1);
        step();
        sabus.axi_bvalid = 1'b0;
        sample();
        check("s.wr_rvalid", sbus.core_rvalid, 1'b1);
        check("s.rd_gnt",    sbus.core_gnt,    1'b1);
        step();
        sbus.core_req = 1'b0; sabus.axi_arready = 1'b1;
        sample();
        check("s.arvalid", sabus.axi_arvalid, 1'b1);
        check("s.araddr",  sabus.axi_araddr,  32'h804);
        check("s.arprot",  sabus.axi_arprot,  3'b100);
        check("s.awprot",  sabus.axi_awprot,  3'b000);
        step();
        sabus.axi_arready = 1'b0;
        sabus.axi_rvalid = 1'b1; sabus.axi_rdata = 32'h77;
        step();
        sabus.axi_rvalid = 1'b0;
        sample();
        check("s.rd_rvalid", sbus.core_rvalid, 1'b1);
        check("s.rd_rdata",  sbus.core_rdata,  32'h77);
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
